// File: rtl/axi2syncreg_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axi2syncreg_pkg
// Description : Shared definitions for the AXI4-Lite to synchronous register
//               bus bridge. Holds the AXI response codes, the bridge FSM state
//               encoding and the read/write grant encoding used by the
//               round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package axi2syncreg_pkg;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Bridge sequencing states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ACC  = 3'd1,
    ST_RD_ACC  = 3'd2,
    ST_WR_RESP = 3'd3,
    ST_RD_RESP = 3'd4
  } state_e;

  // Direction that most recently won arbitration
  typedef enum logic {
    GNT_RD = 1'b0,
    GNT_WR = 1'b1
  } grant_e;

endpackage
`default_nettype wire

// File: rtl/axi_lite_hold_slot.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_hold_slot
// Description : One-entry holding buffer for an AXI valid/ready channel.
//               Accepts a beat when empty, holds it until clr_i, then frees.
//               ready_o is registered: low during reset, high from the first
//               clock after reset release, and high again the cycle after a
//               clear.
// Ports       : clk, rst_n        - clock, async active-low reset
//               valid_i/ready_o   - upstream handshake
//               data_i            - beat payload
//               clr_i             - release the held beat
//               full_o/data_o     - registered slot contents
//               full_nxt_o/data_nxt_o - contents as they will be next cycle
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_hold_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  input  logic             clr_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o,
  output logic             full_nxt_o,
  output logic [WIDTH-1:0] data_nxt_o
);

  logic             full_q, full_d;
  logic             rdy_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic             accept;

  assign accept = valid_i & rdy_q;

  // Clear only ever arrives while full (ready low), so it never races accept.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clr_i) begin
      full_d = 1'b0;
    end else if (accept) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      rdy_q  <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      rdy_q  <= ~full_d;
      data_q <= data_d;
    end
  end

  assign ready_o    = rdy_q;
  assign full_o     = full_q;
  assign data_o     = data_q;
  assign full_nxt_o = full_d;
  assign data_nxt_o = data_d;

endmodule
`default_nettype wire

// File: rtl/axi_lite_sync_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_sync_reg_ctrl
// Description : AXI4-Lite slave that serialises host accesses onto a single
//               synchronous register bus. AW, W and AR are each buffered in a
//               one-entry slot; reads and writes are granted round-robin, one
//               access outstanding at a time. Out-of-range indices return
//               DECERR without touching the bus; an unacknowledged access is
//               abandoned after TIMEOUT cycles with SLVERR.
// Ports       : ACLK, ARESETn            - clock, async active-low reset
//               s_aw*/s_w*/s_b*          - AXI write address/data/response
//               s_ar*/s_r*               - AXI read address/data
//               reg_req/we/idx/wdata/wstrb - register bus request
//               reg_ack/reg_rdata        - register bus completion
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_sync_reg_ctrl
  import axi2syncreg_pkg::*;
#(
  parameter  int ADDR_WIDTH = 12,
  parameter  int DATA_WIDTH = 64,
  parameter  int NUM_REGS   = 3,
  parameter  int TIMEOUT    = 16,
  localparam int STRB_W     = DATA_WIDTH / 8,
  localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [STRB_W-1:0]     s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic                  reg_req,
  output logic                  reg_we,
  output logic [IDX_W-1:0]      reg_idx,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic [STRB_W-1:0]     reg_wstrb,
  input  logic                  reg_ack,
  input  logic [DATA_WIDTH-1:0] reg_rdata
);

  localparam int              IW         = ADDR_WIDTH - 3;
  localparam int              TW         = $clog2(TIMEOUT);
  localparam int              WPW        = DATA_WIDTH + STRB_W;
  localparam logic [IW-1:0]   NUM_REGS_C = IW'(NUM_REGS);
  localparam logic [TW-1:0]   TMO_LAST   = TW'(TIMEOUT - 1);

  // --------------------------------------------------------------------------
  // Holding slots
  // --------------------------------------------------------------------------
  logic                  aw_full, aw_full_nxt, aw_clr;
  logic [ADDR_WIDTH-1:0] aw_addr, aw_addr_nxt;
  logic                  w_full, w_full_nxt, w_clr;
  logic [WPW-1:0]        w_pkt, w_pkt_nxt;
  logic                  ar_full, ar_full_nxt, ar_clr;
  logic [ADDR_WIDTH-1:0] ar_addr, ar_addr_nxt;

  axi_lite_hold_slot #(.WIDTH(ADDR_WIDTH)) u_aw_slot (
    .clk        (ACLK),
    .rst_n      (ARESETn),
    .valid_i    (s_awvalid),
    .ready_o    (s_awready),
    .data_i     (s_awaddr),
    .clr_i      (aw_clr),
    .full_o     (aw_full),
    .data_o     (aw_addr),
    .full_nxt_o (aw_full_nxt),
    .data_nxt_o (aw_addr_nxt)
  );

  axi_lite_hold_slot #(.WIDTH(WPW)) u_w_slot (
    .clk        (ACLK),
    .rst_n      (ARESETn),
    .valid_i    (s_wvalid),
    .ready_o    (s_wready),
    .data_i     ({s_wdata, s_wstrb}),
    .clr_i      (w_clr),
    .full_o     (w_full),
    .data_o     (w_pkt),
    .full_nxt_o (w_full_nxt),
    .data_nxt_o (w_pkt_nxt)
  );

  axi_lite_hold_slot #(.WIDTH(ADDR_WIDTH)) u_ar_slot (
    .clk        (ACLK),
    .rst_n      (ARESETn),
    .valid_i    (s_arvalid),
    .ready_o    (s_arready),
    .data_i     (s_araddr),
    .clr_i      (ar_clr),
    .full_o     (ar_full),
    .data_o     (ar_addr),
    .full_nxt_o (ar_full_nxt),
    .data_nxt_o (ar_addr_nxt)
  );

  // Arbitration looks at next-cycle slot contents so a beat accepted this
  // cycle is granted at once and reaches the register bus the next cycle.
  logic wr_pend, rd_pend, wr_hit, rd_hit;
  assign wr_pend = aw_full_nxt & w_full_nxt;
  assign rd_pend = ar_full_nxt;
  assign wr_hit  = aw_addr_nxt[ADDR_WIDTH-1:3] < NUM_REGS_C;
  assign rd_hit  = ar_addr_nxt[ADDR_WIDTH-1:3] < NUM_REGS_C;

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  state_e                state_q, state_d;
  grant_e                last_grant_q, last_grant_d;
  logic [TW-1:0]         cnt_q, cnt_d;
  logic [1:0]            resp_q, resp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    resp_d       = resp_q;
    rdata_d      = rdata_q;
    aw_clr       = 1'b0;
    w_clr        = 1'b0;
    ar_clr       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_pend && (!rd_pend || (last_grant_q == GNT_RD))) begin
          last_grant_d = GNT_WR;
          cnt_d        = '0;
          if (wr_hit) begin
            state_d = ST_WR_ACC;
          end else begin
            state_d = ST_WR_RESP;
            resp_d  = RESP_DECERR;
          end
        end else if (rd_pend) begin
          last_grant_d = GNT_RD;
          cnt_d        = '0;
          if (rd_hit) begin
            state_d = ST_RD_ACC;
          end else begin
            state_d = ST_RD_RESP;
            resp_d  = RESP_DECERR;
            rdata_d = '0;
          end
        end
      end
      ST_WR_ACC, ST_RD_ACC: begin
        // Ack is checked first so an ack on the final cycle still wins.
        if (reg_ack) begin
          resp_d = RESP_OKAY;
          if (state_q == ST_RD_ACC) begin
            rdata_d = reg_rdata;
            state_d = ST_RD_RESP;
          end else begin
            state_d = ST_WR_RESP;
          end
        end else if (cnt_q == TMO_LAST) begin
          resp_d = RESP_SLVERR;
          if (state_q == ST_RD_ACC) begin
            rdata_d = '0;
            state_d = ST_RD_RESP;
          end else begin
            state_d = ST_WR_RESP;
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_WR_RESP: begin
        if (s_bready) begin
          aw_clr  = 1'b1;
          w_clr   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RD_RESP: begin
        if (s_rready) begin
          ar_clr  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_RD;
      cnt_q        <= '0;
      resp_q       <= RESP_OKAY;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      resp_q       <= resp_d;
      rdata_q      <= rdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: everything is taken from held slots or registers, so the bus
  // fields stay stable for the whole access and responses stay stable until
  // accepted.
  // --------------------------------------------------------------------------
  assign reg_req   = (state_q == ST_WR_ACC) || (state_q == ST_RD_ACC);
  assign reg_we    = (state_q == ST_WR_ACC);
  assign reg_idx   = (state_q == ST_WR_ACC) ? aw_addr[3 +: IDX_W] :
                     (state_q == ST_RD_ACC) ? ar_addr[3 +: IDX_W] : '0;
  assign reg_wdata = reg_we ? w_pkt[STRB_W +: DATA_WIDTH] : '0;
  assign reg_wstrb = reg_we ? w_pkt[0 +: STRB_W] : '0;

  assign s_bvalid  = (state_q == ST_WR_RESP);
  assign s_rvalid  = (state_q == ST_RD_RESP);
  assign s_bresp   = resp_q;
  assign s_rresp   = resp_q;
  assign s_rdata   = rdata_q;

  // Byte-offset bits and unused slot views are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{aw_full, w_full, ar_full, aw_addr, ar_addr,
                         aw_addr_nxt[2:0], ar_addr_nxt[2:0], w_pkt_nxt};

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_sync_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_sync_reg_ctrl
// Description : Scoreboard bench for axi_lite_sync_reg_ctrl. Directed tasks
//               push expected B/R responses into queues; a monitor pops and
//               compares on each handshake. A small register-file model
//               (cnt, run, trigger; trigger adds into cnt) answers reg_req
//               with a programmable ack delay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_sync_reg_ctrl;
  import axi2syncreg_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b1;
  logic [11:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [63:0] s_wdata = '0;
  logic [7:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b1;
  logic [11:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b1;
  logic        reg_req, reg_we;
  logic [1:0]  reg_idx;
  logic [63:0] reg_wdata;
  logic [7:0]  reg_wstrb;
  logic        reg_ack = 1'b0;
  logic [63:0] reg_rdata = '0;

  always #5 ACLK = ~ACLK;

  axi_lite_sync_reg_ctrl #(
    .ADDR_WIDTH(12), .DATA_WIDTH(64), .NUM_REGS(3), .TIMEOUT(16)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .reg_req(reg_req), .reg_we(reg_we), .reg_idx(reg_idx),
    .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Scoreboard queues and monitor
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [1:0]  resp;
    logic [63:0] data;
  } rexp_t;

  rexp_t      rd_q[$];
  logic [1:0] wr_q[$];

  always @(negedge ACLK) begin
    if (ARESETn && s_rvalid && s_rready) begin
      if (rd_q.size() == 0) begin
        chk("rd_unexpected", 64'(s_rvalid), 64'(0));
      end else begin
        chk("rresp", 64'(s_rresp), 64'(rd_q[0].resp));
        chk("rdata", s_rdata, rd_q[0].data);
        void'(rd_q.pop_front());
      end
    end
    if (ARESETn && s_bvalid && s_bready) begin
      if (wr_q.size() == 0) begin
        chk("wr_unexpected", 64'(s_bvalid), 64'(0));
      end else begin
        chk("bresp", 64'(s_bresp), 64'(wr_q[0]));
        void'(wr_q.pop_front());
      end
    end
  end

  // --------------------------------------------------------------------------
  // Register-file model: idx0 cnt, idx1 run, idx2 trigger (adds into cnt)
  // --------------------------------------------------------------------------
  logic [63:0] regs [4] = '{default: 64'd0};
  int          ack_dly = 0;
  int          cur_len = 0;
  int          last_len = 0;
  int          acc_cnt = 0;
  logic        acc_we_log[$];
  logic        cap_we = 1'b0;
  logic [1:0]  cap_idx = '0;
  logic [63:0] cap_wdata = '0;
  logic [7:0]  cap_strb = '0;

  function automatic logic [63:0] strb_mask(input logic [7:0] s);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{s[b]}};
    return m;
  endfunction

  always @(negedge ACLK) begin
    if (reg_req) begin
      if (cur_len == 0) begin
        acc_cnt <= acc_cnt + 1;
        acc_we_log.push_back(reg_we);
        cap_we    <= reg_we;
        cap_idx   <= reg_idx;
        cap_wdata <= reg_wdata;
        cap_strb  <= reg_wstrb;
      end else begin
        chk("reg_ctl_stable", 64'({reg_we, reg_idx, reg_wstrb}), 64'({cap_we, cap_idx, cap_strb}));
        chk("reg_wdata_stable", reg_wdata, cap_wdata);
      end
      if (cur_len == ack_dly) begin
        reg_ack   <= 1'b1;
        reg_rdata <= reg_we ? 64'd0 : regs[reg_idx];
        if (reg_we) begin
          case (reg_idx)
            2'd0: regs[0] <= (regs[0] & ~strb_mask(reg_wstrb)) | (reg_wdata & strb_mask(reg_wstrb));
            2'd1: regs[1] <= (regs[1] & ~strb_mask(reg_wstrb)) | (reg_wdata & strb_mask(reg_wstrb));
            2'd2: regs[0] <= regs[0] + (reg_wdata & strb_mask(reg_wstrb));
            default: ;
          endcase
        end
      end else begin
        reg_ack   <= 1'b0;
        reg_rdata <= '0;
      end
      cur_len <= cur_len + 1;
    end else begin
      reg_ack   <= 1'b0;
      reg_rdata <= '0;
      if (cur_len != 0) begin
        last_len <= cur_len;
        cur_len  <= 0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Drivers (entered and left at posedge+1)
  // --------------------------------------------------------------------------
  task automatic ar_send(input logic [11:0] a);
    bit hs = 1'b0;
    s_araddr  = a;
    s_arvalid = 1'b1;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge ACLK); hs = s_arready;
      @(posedge ACLK); #1;
    end
    s_arvalid = 1'b0;
    chk("ar_handshake", 64'(hs), 64'(1));
  endtask

  task automatic aw_send(input logic [11:0] a);
    bit hs = 1'b0;
    s_awaddr  = a;
    s_awvalid = 1'b1;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge ACLK); hs = s_awready;
      @(posedge ACLK); #1;
    end
    s_awvalid = 1'b0;
    chk("aw_handshake", 64'(hs), 64'(1));
  endtask

  task automatic w_send(input logic [63:0] d, input logic [7:0] s);
    bit hs = 1'b0;
    s_wdata  = d;
    s_wstrb  = s;
    s_wvalid = 1'b1;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge ACLK); hs = s_wready;
      @(posedge ACLK); #1;
    end
    s_wvalid = 1'b0;
    chk("w_handshake", 64'(hs), 64'(1));
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] d, input logic [7:0] s);
    fork
      aw_send(a);
      w_send(d, s);
    join
  endtask

  task automatic push_rd(input logic [1:0] r, input logic [63:0] d);
    rexp_t e;
    e.resp = r;
    e.data = d;
    rd_q.push_back(e);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((rd_q.size() != 0 || wr_q.size() != 0) && n < 300) begin
      @(negedge ACLK);
      n++;
    end
    chk("resp_in_time", 64'(n < 300), 64'(1));
    @(posedge ACLK); #1;
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  int acc0;

  initial begin
    #2 ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_ready", 64'({s_awready, s_wready, s_arready}), 64'(0));
    chk("rst_valid_req", 64'({s_bvalid, s_rvalid, reg_req}), 64'(0));
    chk("rst_resp", 64'({s_bresp, s_rresp}), 64'(0));
    chk("rst_rdata", s_rdata, 64'd0);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("ready_after_rst", 64'({s_awready, s_wready, s_arready}), 64'b111);
    @(posedge ACLK); #1;

    // Reads after reset, with read latency
    acc0 = acc_cnt;
    push_rd(RESP_OKAY, 64'd0);
    ar_send(12'h000);
    @(negedge ACLK);
    chk("rd_lat_req", 64'({reg_req, reg_we, s_rvalid}), 64'b100);
    @(negedge ACLK);
    chk("rd_lat_rvalid", 64'(s_rvalid), 64'(1));
    wait_done();
    chk("rd0_one_req", 64'(acc_cnt - acc0), 64'(1));
    acc0 = acc_cnt;
    push_rd(RESP_OKAY, 64'd0);
    ar_send(12'h008);
    wait_done();
    chk("rd8_one_req", 64'(acc_cnt - acc0), 64'(1));

    // Trigger writes 1,2,3, then cnt reads back 6
    wr_q.push_back(RESP_OKAY);
    wr(12'h010, 64'd1, 8'hFF);
    @(negedge ACLK);
    chk("wr_lat_req", 64'({reg_req, reg_we, s_bvalid}), 64'b110);
    @(negedge ACLK);
    chk("wr_lat_bvalid", 64'(s_bvalid), 64'(1));
    wait_done();
    wr_q.push_back(RESP_OKAY);
    wr(12'h010, 64'd2, 8'hFF);
    wait_done();
    wr_q.push_back(RESP_OKAY);
    wr(12'h010, 64'd3, 8'hFF);
    wait_done();
    push_rd(RESP_OKAY, 64'd6);
    ar_send(12'h000);
    wait_done();

    // W leads AW by three cycles
    acc0 = acc_cnt;
    wr_q.push_back(RESP_OKAY);
    fork
      w_send(64'd1, 8'hFF);
      begin
        repeat (3) @(posedge ACLK);
        #1;
        aw_send(12'h008);
      end
    join
    wait_done();
    chk("w_first_one_req", 64'(acc_cnt - acc0), 64'(1));
    chk("w_first_we_idx", 64'({cap_we, cap_idx}), 64'b101);
    chk("w_first_wdata", cap_wdata, 64'd1);

    // Read back run with response back-pressure
    s_rready = 1'b0;
    push_rd(RESP_OKAY, 64'd1);
    ar_send(12'h008);
    repeat (4) @(negedge ACLK);
    chk("rvalid_held", 64'(s_rvalid), 64'(1));
    chk("rdata_held", s_rdata, 64'd1);
    @(posedge ACLK); #1;
    s_rready = 1'b1;
    wait_done();

    // Simultaneous read and write, twice: WR,RD,WR,RD
    acc_we_log.delete();
    wr_q.push_back(RESP_OKAY);
    push_rd(RESP_OKAY, 64'd5);
    fork
      aw_send(12'h000);
      w_send(64'd5, 8'hFF);
      ar_send(12'h000);
    join
    wait_done();
    wr_q.push_back(RESP_OKAY);
    push_rd(RESP_OKAY, 64'd7);
    fork
      aw_send(12'h008);
      w_send(64'd7, 8'hFF);
      ar_send(12'h008);
    join
    wait_done();
    chk("grant_count", 64'(acc_we_log.size()), 64'(4));
    if (acc_we_log.size() == 4)
      chk("grant_order", 64'({acc_we_log[0], acc_we_log[1], acc_we_log[2], acc_we_log[3]}), 64'b1010);

    // Zero strobe is still issued and leaves run unchanged
    acc0 = acc_cnt;
    wr_q.push_back(RESP_OKAY);
    wr(12'h008, 64'hFF, 8'h00);
    wait_done();
    chk("strb0_one_req", 64'(acc_cnt - acc0), 64'(1));
    chk("strb0_passthru", 64'({cap_we, cap_strb}), 64'h100);
    push_rd(RESP_OKAY, 64'd7);
    ar_send(12'h008);
    wait_done();

    // Decode errors: no bus access
    acc0 = acc_cnt;
    push_rd(RESP_DECERR, 64'd0);
    ar_send(12'h018);
    wait_done();
    wr_q.push_back(RESP_DECERR);
    wr(12'h020, 64'hAB, 8'hFF);
    wait_done();
    chk("decerr_no_req", 64'(acc_cnt - acc0), 64'(0));

    // Ack on the final allowed cycle still completes OKAY
    ack_dly = 15;
    push_rd(RESP_OKAY, 64'd5);
    ar_send(12'h000);
    wait_done();
    chk("late_ack_len", 64'(last_len), 64'(16));

    // No ack at all: SLVERR after 16 request cycles
    ack_dly = 1000;
    push_rd(RESP_SLVERR, 64'd0);
    ar_send(12'h008);
    wait_done();
    chk("rd_tmo_len", 64'(last_len), 64'(16));
    wr_q.push_back(RESP_SLVERR);
    wr(12'h008, 64'd9, 8'hFF);
    wait_done();
    chk("wr_tmo_len", 64'(last_len), 64'(16));

    // Reset asserted mid-access drops everything at once
    ar_send(12'h000);
    repeat (3) @(negedge ACLK);
    chk("pre_rst_req", 64'(reg_req), 64'(1));
    ARESETn = 1'b0;
    #1;
    chk("async_rst_req_valid", 64'({reg_req, s_rvalid, s_bvalid}), 64'(0));
    chk("async_rst_ready", 64'({s_awready, s_wready, s_arready}), 64'(0));
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    ack_dly = 0;
    push_rd(RESP_OKAY, 64'd7);
    ar_send(12'h008);
    wait_done();

    repeat (3) @(posedge ACLK);
    chk("rd_q_empty", 64'(rd_q.size()), 64'(0));
    chk("wr_q_empty", 64'(wr_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
